// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder. Bits are shifted into a prefix register and matched
// against a loadable code table. Decoded symbol indices leave through a valid/ready handshake.
module huffman_decoder #(
   parameter int TOTAL_SYMBOLS = 10,
   parameter int ADDR_WIDTH    = 4,
   parameter int MAX_CODE_LEN  = 9,
   parameter int LEN_WIDTH     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    tbl_we,
   input  logic [ADDR_WIDTH-1:0]   tbl_idx,
   input  logic [MAX_CODE_LEN-1:0] tbl_code,
   input  logic [LEN_WIDTH-1:0]    tbl_len,
   input  logic                    bit_in,
   input  logic                    bit_valid,
   output logic                    bit_ready,
   output logic [ADDR_WIDTH-1:0]   sym_out,
   output logic                    sym_valid,
   input  logic                    sym_ready,
   output logic                    err,
   output logic [15:0]             sym_count
);

   typedef enum logic [1:0] {ACCUM, EMIT, ERROR} state_t;

   state_t                  state_reg, state_next;
   logic [MAX_CODE_LEN-1:0] acc_reg, acc_next;
   logic [LEN_WIDTH-1:0]    cnt_reg, cnt_next;
   logic [ADDR_WIDTH-1:0]   sym_out_reg, sym_out_next;
   logic                    sym_valid_reg, sym_valid_next;
   logic                    err_reg, err_next;
   logic [15:0]             sym_count_reg, sym_count_next;

   logic [MAX_CODE_LEN-1:0] tbl_code_reg [TOTAL_SYMBOLS];
   logic [LEN_WIDTH-1:0]    tbl_len_reg  [TOTAL_SYMBOLS];

   logic [MAX_CODE_LEN-1:0]  acc_n;
   logic [LEN_WIDTH-1:0]     cnt_n;
   logic [MAX_CODE_LEN-1:0]  code_mask;
   logic [TOTAL_SYMBOLS-1:0] match_vec;
   logic                     match_found;
   logic [ADDR_WIDTH-1:0]    match_idx;

   assign acc_n = {acc_reg[MAX_CODE_LEN-2:0], bit_in};
   assign cnt_n = cnt_reg + LEN_WIDTH'(1);

   // Only the low cnt_n bits of code and prefix take part in the compare.
   always_comb begin
      code_mask = '0;
      for (int b = 0; b < MAX_CODE_LEN; b++) begin
         code_mask[b] = (LEN_WIDTH'(b) < cnt_n);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < TOTAL_SYMBOLS; gi++) begin : g_entry
         // Indices at or above TOTAL_SYMBOLS address no entry, so such writes fall away.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               tbl_code_reg[gi] <= '0;
               tbl_len_reg[gi]  <= '0;
            end else if (tbl_we && (tbl_idx == ADDR_WIDTH'(gi))) begin
               tbl_code_reg[gi] <= tbl_code;
               tbl_len_reg[gi]  <= tbl_len;
            end
         end

         // cnt_n never exceeds MAX_CODE_LEN and is never 0, so oversized or zero lengths never match.
         assign match_vec[gi] = (tbl_len_reg[gi] == cnt_n) &&
                                (((tbl_code_reg[gi] ^ acc_n) & code_mask) == '0);
      end
   endgenerate

   always_comb begin
      match_found = 1'b0;
      match_idx   = '0;
      for (int i = TOTAL_SYMBOLS - 1; i >= 0; i--) begin
         if (match_vec[i]) begin
            match_found = 1'b1;
            match_idx   = ADDR_WIDTH'(i);
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      acc_next       = acc_reg;
      cnt_next       = cnt_reg;
      sym_out_next   = sym_out_reg;
      sym_valid_next = sym_valid_reg;
      err_next       = err_reg;
      sym_count_next = sym_count_reg;

      if (flush) begin
         state_next     = ACCUM;
         acc_next       = '0;
         cnt_next       = '0;
         sym_valid_next = 1'b0;
         err_next       = 1'b0;
      end else begin
         unique case (state_reg)
            ACCUM: begin
               if (bit_valid) begin
                  if (match_found) begin
                     sym_out_next   = match_idx;
                     sym_valid_next = 1'b1;
                     acc_next       = '0;
                     cnt_next       = '0;
                     state_next     = EMIT;
                  end else if (cnt_n == LEN_WIDTH'(MAX_CODE_LEN)) begin
                     err_next   = 1'b1;
                     state_next = ERROR;
                  end else begin
                     acc_next = acc_n;
                     cnt_next = cnt_n;
                  end
               end
            end
            EMIT: begin
               if (sym_ready) begin
                  sym_valid_next = 1'b0;
                  sym_count_next = sym_count_reg + 16'd1;
                  state_next     = ACCUM;
               end
            end
            default: begin
               state_next = ERROR;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ACCUM;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         sym_out_reg   <= '0;
         sym_valid_reg <= 1'b0;
         err_reg       <= 1'b0;
         sym_count_reg <= '0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         cnt_reg       <= cnt_next;
         sym_out_reg   <= sym_out_next;
         sym_valid_reg <= sym_valid_next;
         err_reg       <= err_next;
         sym_count_reg <= sym_count_next;
      end
   end

   assign bit_ready = (state_reg == ACCUM);
   assign sym_out   = sym_out_reg;
   assign sym_valid = sym_valid_reg;
   assign err       = err_reg;
   assign sym_count = sym_count_reg;

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: directed scenarios plus random symbol streams checked against a
// prefix-matching reference decoder held in plain arrays.
module tb_huffman_decoder;

   localparam int NSYM = 10;
   localparam int MAXL = 9;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        tbl_we = 1'b0;
   logic [3:0]  tbl_idx = '0;
   logic [8:0]  tbl_code = '0;
   logic [3:0]  tbl_len = '0;
   logic        bit_in = 1'b0;
   logic        bit_valid = 1'b0;
   logic        bit_ready;
   logic [3:0]  sym_out;
   logic        sym_valid;
   logic        sym_ready = 1'b0;
   logic        err;
   logic [15:0] sym_count;

   int total = 0;
   int bad = 0;
   int m_code [NSYM];
   int m_len  [NSYM];

   huffman_decoder dut (
      .clk(clk), .rst(rst), .flush(flush), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
      .tbl_code(tbl_code), .tbl_len(tbl_len), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready), .sym_out(sym_out), .sym_valid(sym_valid),
      .sym_ready(sym_ready), .err(err), .sym_count(sym_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int idx, input int code, input int len);
      tbl_we = 1'b1; tbl_idx = 4'(idx); tbl_code = 9'(code); tbl_len = 4'(len);
      tick();
      tbl_we = 1'b0;
      if (idx < NSYM) begin
         m_code[idx] = code;
         m_len[idx]  = len;
      end
   endtask

   task automatic clear_table();
      for (int i = 0; i < NSYM; i++) load(i, 0, 0);
   endtask

   task automatic load_base();
      clear_table();
      load(0, 0, 1); load(1, 2, 2); load(2, 6, 3); load(3, 7, 3);
   endtask

   // Reference: grow a prefix bit by bit, take the lowest entry whose length and code fit.
   task automatic model_decode(input int bits[$], output int syms[$], output int cycles);
      int pre = 0;
      int n = 0;
      syms = {};
      cycles = 0;
      foreach (bits[k]) begin
         pre = (pre << 1) | bits[k];
         n++;
         for (int i = 0; i < NSYM; i++) begin
            if (m_len[i] == n && (m_code[i] & ((1 << n) - 1)) == pre) begin
               syms.push_back(i);
               cycles += n + 1;
               pre = 0;
               n = 0;
               break;
            end
         end
      end
   endtask

   task automatic run_stream(input int bits_in[$], input int ready_pct, input string name);
      int bits[$];
      int exp[$];
      int exp_cycles;
      int cycles = 0;
      int nsym;
      logic acc, hs;
      logic [3:0] got;
      logic [15:0] start_cnt, exp_cnt;
      int want;
      bits = bits_in;
      model_decode(bits, exp, exp_cycles);
      nsym = exp.size();
      start_cnt = sym_count;
      while (exp.size() > 0 && cycles < 20000) begin
         sym_ready = ($urandom_range(0, 99) < ready_pct);
         bit_valid = (bits.size() > 0);
         bit_in = (bits.size() > 0) ? bits[0][0] : 1'b0;
         acc = bit_valid && bit_ready;
         hs = sym_valid && sym_ready;
         got = sym_out;
         total++;
         if (bit_ready !== !sym_valid) begin
            bad++;
            $display("FAIL %s ready_vs_valid: bit_ready=%b sym_valid=%b", name, bit_ready, sym_valid);
         end
         tick();
         cycles++;
         if (acc) void'(bits.pop_front());
         if (hs) begin
            want = exp.pop_front();
            total++;
            if (got !== 4'(want)) begin
               bad++;
               $display("FAIL %s symbol: got %0d want %0d", name, got, want);
            end else begin
               $display("%s: sym %0d handed off", name, got);
            end
         end
      end
      bit_valid = 1'b0;
      sym_ready = 1'b0;
      total++;
      if (exp.size() != 0) begin
         bad++;
         $display("FAIL %s timeout: %0d symbols still pending", name, exp.size());
      end
      exp_cnt = start_cnt + 16'(nsym);
      total++;
      if (sym_count !== exp_cnt) begin
         bad++;
         $display("FAIL %s sym_count: got %h want %h", name, sym_count, exp_cnt);
      end
      if (ready_pct >= 100) begin
         total++;
         if (cycles != exp_cycles) begin
            bad++;
            $display("FAIL %s cycles: got %0d want %0d", name, cycles, exp_cycles);
         end
      end
   endtask

   task automatic test_reset();
      total++;
      if ({sym_valid, err, bit_ready, sym_out, sym_count} !== {1'b0, 1'b0, 1'b1, 4'd0, 16'd0}) begin
         bad++;
         $display("FAIL reset: got v=%b e=%b r=%b s=%0d c=%0d want 0 0 1 0 0",
                  sym_valid, err, bit_ready, sym_out, sym_count);
      end
   endtask

   task automatic test_basic();
      load_base();
      sym_ready = 1'b1; bit_valid = 1'b1;
      bit_in = 1'b1; tick();
      bit_in = 1'b1; tick();
      total++;
      if (sym_valid !== 1'b0) begin
         bad++; $display("FAIL basic early_valid: got %b want 0", sym_valid);
      end
      bit_in = 1'b0; tick();
      bit_valid = 1'b0;
      total++;
      if (sym_valid !== 1'b1 || sym_out !== 4'd2) begin
         bad++; $display("FAIL basic sym110: got v=%b s=%0d want v=1 s=2", sym_valid, sym_out);
      end
      tick();
      sym_ready = 1'b0;
      total++;
      if (sym_valid !== 1'b0 || sym_count !== 16'd1) begin
         bad++; $display("FAIL basic handoff: got v=%b c=%0d want v=0 c=1", sym_valid, sym_count);
      end
      run_stream('{0, 1, 0, 1, 1, 1}, 100, "basic");
   endtask

   task automatic test_backpressure();
      logic [15:0] c0;
      load_base();
      sym_ready = 1'b0; bit_valid = 1'b1;
      bit_in = 1'b1; tick();
      bit_in = 1'b0; tick();
      c0 = sym_count;
      for (int k = 0; k < 5; k++) begin
         total++;
         if (sym_valid !== 1'b1 || sym_out !== 4'd1 || bit_ready !== 1'b0) begin
            bad++;
            $display("FAIL backpressure stall%0d: got v=%b s=%0d r=%b want v=1 s=1 r=0",
                     k, sym_valid, sym_out, bit_ready);
         end
         tick();
      end
      sym_ready = 1'b1;
      tick();
      total++;
      if (sym_valid !== 1'b0 || bit_ready !== 1'b1 || sym_count !== c0 + 16'd1) begin
         bad++;
         $display("FAIL backpressure release: got v=%b r=%b c=%0d want v=0 r=1 c=%0d",
                  sym_valid, bit_ready, sym_count, c0 + 16'd1);
      end
      tick();
      bit_valid = 1'b0;
      total++;
      if (sym_valid !== 1'b1 || sym_out !== 4'd0) begin
         bad++; $display("FAIL backpressure held_bit: got v=%b s=%0d want v=1 s=0", sym_valid, sym_out);
      end
      tick();
      sym_ready = 1'b0;
   endtask

   task automatic test_error();
      logic [15:0] c0;
      clear_table();
      load(0, 0, 1);
      bit_valid = 1'b1; bit_in = 1'b1;
      for (int k = 1; k <= MAXL; k++) begin
         tick();
         total++;
         if (err !== (k == MAXL)) begin
            bad++; $display("FAIL error bit%0d: got err=%b want %b", k, err, k == MAXL);
         end
      end
      tick(); tick();
      bit_valid = 1'b0;
      total++;
      if (err !== 1'b1 || bit_ready !== 1'b0 || sym_valid !== 1'b0) begin
         bad++;
         $display("FAIL error sticky: got e=%b r=%b v=%b want 1 0 0", err, bit_ready, sym_valid);
      end
      flush = 1'b1; tick(); flush = 1'b0;
      total++;
      if (err !== 1'b0 || bit_ready !== 1'b1) begin
         bad++; $display("FAIL error flush: got e=%b r=%b want 0 1", err, bit_ready);
      end
      bit_valid = 1'b1; bit_in = 1'b0; tick(); bit_valid = 1'b0;
      total++;
      if (sym_valid !== 1'b1 || sym_out !== 4'd0) begin
         bad++; $display("FAIL error after_flush: got v=%b s=%0d want v=1 s=0", sym_valid, sym_out);
      end
      c0 = sym_count;
      sym_ready = 1'b1; flush = 1'b1; tick(); flush = 1'b0; sym_ready = 1'b0;
      total++;
      if (sym_valid !== 1'b0 || sym_count !== c0 || bit_ready !== 1'b1) begin
         bad++;
         $display("FAIL flush_priority: got v=%b c=%0d r=%b want v=0 c=%0d r=1",
                  sym_valid, sym_count, bit_ready, c0);
      end
   endtask

   task automatic test_priority();
      clear_table();
      load(4, 1, 2); load(7, 1, 2);
      run_stream('{0, 1}, 100, "priority");
      load(12, 1, 1);
      load(3, 1, 15);
      load(9, 3, 2);
      run_stream('{1, 1}, 100, "invalid_entries");
   endtask

   task automatic test_rst_midcode();
      load_base();
      bit_valid = 1'b1; bit_in = 1'b1; tick(); bit_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      total++;
      if ({sym_valid, err, bit_ready, sym_out, sym_count} !== {1'b0, 1'b0, 1'b1, 4'd0, 16'd0}) begin
         bad++;
         $display("FAIL async_rst: got v=%b e=%b r=%b s=%0d c=%0d want 0 0 1 0 0",
                  sym_valid, err, bit_ready, sym_out, sym_count);
      end
      for (int i = 0; i < NSYM; i++) m_len[i] = 0;
      @(negedge clk) rst = 1'b0;
      tick();
      bit_valid = 1'b1; bit_in = 1'b0;
      for (int k = 1; k <= MAXL; k++) begin
         tick();
         total++;
         if (err !== (k == MAXL) || sym_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_table bit%0d: got e=%b v=%b want e=%b v=0", k, err, sym_valid, k == MAXL);
         end
      end
      bit_valid = 1'b0;
      load_base();
      flush = 1'b1; tick(); flush = 1'b0;
      run_stream('{0}, 100, "reload");
   endtask

   task automatic test_random();
      int perm[NSYM];
      int bits[$];
      int s, r, len, code;
      for (int i = 0; i < NSYM; i++) perm[i] = i;
      for (int i = NSYM - 1; i > 0; i--) begin
         int j = int'($urandom_range(0, i));
         int t = perm[i];
         perm[i] = perm[j];
         perm[j] = t;
      end
      clear_table();
      for (int i = 0; i < NSYM; i++) begin
         r = perm[i];
         len = (r < MAXL) ? r + 1 : MAXL;
         code = (r < MAXL) ? (1 << (r + 1)) - 2 : (1 << MAXL) - 1;
         load(i, code, len);
      end
      for (int pass = 0; pass < 2; pass++) begin
         bits = {};
         for (int n = 0; n < 60; n++) begin
            s = int'($urandom_range(0, NSYM - 1));
            for (int b = m_len[s] - 1; b >= 0; b--) bits.push_back((m_code[s] >> b) & 1);
         end
         run_stream(bits, (pass == 0) ? 55 : 100, (pass == 0) ? "random_bp" : "random_full");
      end
   endtask

   task automatic test_wrap();
      load_base();
      force dut.sym_count_reg = 16'hFFFE;
      #1;
      release dut.sym_count_reg;
      run_stream('{0}, 100, "wrap1");
      run_stream('{0}, 100, "wrap2");
      total++;
      if (sym_count !== 16'h0000) begin
         bad++; $display("FAIL wrap: got %h want 0000", sym_count);
      end
      run_stream('{0}, 100, "wrap3");
   endtask

   initial begin
      for (int i = 0; i < NSYM; i++) begin
         m_code[i] = 0;
         m_len[i] = 0;
      end
      #12 rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_error();
      test_priority();
      test_rst_midcode();
      test_random();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
